io_out_port: RTL

Output-side peripheral for the CPU's IO instructions. It watches the control-state bus driven by the instruction sequencer and captures the CPU data bus on every `STATE_MOUT_STORE` or `STATE_ROUT_STORE` cycle. Each captured byte goes into a small FIFO, tagged with its source. The FIFO drains to an external device over a valid/ready handshake, and the block reports fill status and a sticky overflow flag.

---
 rtl/io_out_port_if.sv | 24 ++
 rtl/io_out_port.sv | 83 ++++++++
 2 files changed

// File: rtl/io_out_port_if.sv
// Bus bundle between the instruction sequencer / output device and io_out_port.
// The slave modport is the peripheral's view; master is the environment's view.
interface io_out_port_if;
  logic [7:0] state;
  logic [7:0] data;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] tx_count;

  modport master (
    output state, data, out_ready,
    input  out_data, out_src, out_valid, full, empty, overflow, tx_count
  );

  modport slave (
    input  state, data, out_ready,
    output out_data, out_src, out_valid, full, empty, overflow, tx_count
  );
endinterface

// File: rtl/io_out_port.sv
// IO output port: captures the CPU data bus on MOUT/ROUT store states into a
// source-tagged show-ahead FIFO that drains over a valid/ready handshake.
module io_out_port #(
  parameter int unsigned DEPTH            = 4,
  parameter logic [7:0]  STATE_MOUT_STORE = 8'h31,
  parameter logic [7:0]  STATE_ROUT_STORE = 8'h32
) (
  input logic         clk,
  input logic         reset,
  io_out_port_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 9;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic [7:0]    tx_count_q;

  logic is_full;
  logic is_empty;
  logic push_req;
  logic push_src;
  logic pop;
  logic push;

  // Store-state decode and handshake qualification
  always_comb begin
    is_full  = (count == CW'(DEPTH));
    is_empty = (count == '0);
    push_src = (bus.state == STATE_ROUT_STORE);
    push_req = (bus.state == STATE_MOUT_STORE) || push_src;
    pop      = !is_empty && bus.out_ready;
    push     = push_req && (!is_full || pop);
  end

  // Entry storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {push_src, bus.data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      tx_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + AW'(1);
        tx_count_q <= tx_count_q + 8'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A store that finds the FIFO full with no concurrent pop is lost
      if (push_req && is_full && !pop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.out_data  = mem[rd_ptr][7:0];
  assign bus.out_src   = mem[rd_ptr][8];
  assign bus.out_valid = !is_empty;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.overflow  = overflow_q;
  assign bus.tx_count  = tx_count_q;

endmodule
